event_scheduler: RTL

- Sequences the PHOLD event datapath: owns the enqueue/dequeue strobes of the priority event queue and dispatches queue-head events to idle cores.
- Collects new events from cores by round-robin arbitration and injects the initial event population.
- Computes global virtual time (GVT) and detects end of simulation, including draining in-flight work before reporting done.
- Sits between the event queue (prio_q) and the core array, replacing ad-hoc top-level glue.

---
 rtl/event_scheduler_pkg.sv | 13 +
 rtl/event_scheduler_if.sv | 28 ++
 rtl/event_scheduler_rr_arb.sv | 40 ++++
 rtl/event_scheduler.sv | 135 +++++++++++++
 4 files changed

// File: rtl/event_scheduler_pkg.sv
// Shared types for the PHOLD event datapath: event word layout and scheduler states.
package event_scheduler_pkg;
  localparam int unsigned TW  = 13;
  localparam int unsigned LPW = 3;
  localparam int unsigned EW  = TW + LPW;

  typedef struct packed {
    logic [TW-1:0]  ts;
    logic [LPW-1:0] lp;
  } event_t;

  typedef enum logic [2:0] {IDLE, INIT, RUN, DRAIN, DONE} state_t;
endpackage

// File: rtl/event_scheduler_if.sv
// Queue and core-array signals of the event scheduler; master is the scheduler side.
interface event_scheduler_if #(
  parameter int unsigned NCORE  = 4,
  parameter int unsigned QDEPTH = 16
);
  import event_scheduler_pkg::*;
  localparam int unsigned CW = $clog2(QDEPTH) + 1;

  logic                q_enq;
  event_t              q_enq_data;
  logic                q_deq;
  event_t              q_head;
  logic [CW-1:0]       q_count;
  logic [NCORE-1:0]    disp_vld;
  event_t              disp_data;
  logic [NCORE-1:0]    new_vld;
  logic [NCORE*EW-1:0] new_data;
  logic [NCORE-1:0]    new_ack;

  modport master (
    output q_enq, q_enq_data, q_deq, disp_vld, disp_data, new_ack,
    input  q_head, q_count, new_vld, new_data
  );
  modport slave (
    input  q_enq, q_enq_data, q_deq, disp_vld, disp_data, new_ack,
    output q_head, q_count, new_vld, new_data
  );
endinterface

// File: rtl/event_scheduler_rr_arb.sv
// Round-robin arbiter: lowest requester at or after the pointer wins; pointer moves past the winner.
module rr_arb #(
  parameter int unsigned N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic         adv,
  output logic [N-1:0] gnt,
  output logic         vld
);
  localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr;
  logic [PW-1:0] sel;
  logic [PW-1:0] k;

  always_comb begin
    gnt = '0;
    vld = 1'b0;
    sel = ptr;
    k   = '0;
    for (int unsigned i = 0; i < N; i++) begin
      k = PW'((32'(ptr) + i) % N);
      if (!vld && req[k]) begin
        gnt[k] = 1'b1;
        sel    = k;
        vld    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (adv && vld) begin
      ptr <= (sel == PW'(N - 1)) ? '0 : sel + PW'(1);
    end
  end
endmodule

// File: rtl/event_scheduler.sv
// PHOLD scheduler: seeds the queue, arbitrates core events into it, dispatches to idle cores,
// tracks GVT and drains in-flight work before signalling done.
module event_scheduler
  import event_scheduler_pkg::*;
#(
  parameter int unsigned NCORE  = 4,
  parameter int unsigned NLP    = 8,
  parameter int unsigned QDEPTH = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [TW-1:0]       end_time,
  output logic                done,
  output logic [TW-1:0]       gvt,
  output logic                causality_err,
  event_scheduler_if.master   bus
);
  localparam int unsigned CW = $clog2(QDEPTH) + 1;
  localparam logic [CW-1:0] QCAP = CW'(QDEPTH);

  state_t           state, state_nxt;
  logic [LPW-1:0]   init_cnt;
  logic [NCORE-1:0] busy;
  logic [TW-1:0]    inflight [NCORE];
  event_t           new_ev [NCORE];
  event_t           enq_sel;
  logic [NCORE-1:0] recv_req, recv_gnt, disp_req, disp_gnt;
  logic             recv_vld, disp_go;
  logic             min_v;
  logic [TW-1:0]    min_t;

  function automatic logic [TW:0] gvt_min(
    input logic [NCORE-1:0] b,
    input logic [TW-1:0]    t [NCORE],
    input logic             hv,
    input logic [TW-1:0]    ht
  );
    logic [TW-1:0] m;
    logic          v;
    m = ht;
    v = hv;
    for (int unsigned i = 0; i < NCORE; i++) begin
      if (b[i] && (!v || t[i] < m)) begin
        m = t[i];
        v = 1'b1;
      end
    end
    return {v, m};
  endfunction

  always_comb begin
    enq_sel = '0;
    for (int unsigned i = 0; i < NCORE; i++) begin
      new_ev[i] = bus.new_data[i*EW +: EW];
      if (recv_gnt[i]) enq_sel = new_ev[i];
    end
  end

  // Enqueue outranks dispatch, so the dispatch arbiter only sees requests when nothing was acked.
  assign recv_req = ((state == RUN || state == DRAIN) && bus.q_count < QCAP) ? bus.new_vld : '0;
  assign disp_req = (state == RUN && !recv_vld && bus.q_count != '0 && gvt <= end_time)
                    ? ~busy : '0;

  rr_arb #(.N(NCORE)) u_recv_arb (
    .clk(clk), .rst_n(rst_n), .req(recv_req), .adv(recv_vld), .gnt(recv_gnt), .vld(recv_vld)
  );

  rr_arb #(.N(NCORE)) u_disp_arb (
    .clk(clk), .rst_n(rst_n), .req(disp_req), .adv(disp_go), .gnt(disp_gnt), .vld(disp_go)
  );

  always_comb begin
    {min_v, min_t} = gvt_min(busy, inflight, bus.q_count != '0, bus.q_head.ts);
  end

  always_comb begin
    state_nxt      = state;
    bus.q_enq      = 1'b0;
    bus.q_enq_data = '0;
    bus.q_deq      = 1'b0;
    bus.disp_vld   = '0;
    bus.disp_data  = '0;
    bus.new_ack    = '0;
    done           = 1'b0;
    if (recv_vld) begin
      bus.new_ack    = recv_gnt;
      bus.q_enq      = 1'b1;
      bus.q_enq_data = enq_sel;
    end
    if (disp_go) begin
      bus.disp_vld  = disp_gnt;
      bus.q_deq     = 1'b1;
      bus.disp_data = bus.q_head;
    end
    case (state)
      IDLE:    if (start) state_nxt = INIT;
      INIT: begin
        bus.q_enq      = 1'b1;
        bus.q_enq_data = '{ts: '0, lp: init_cnt};
        if (init_cnt == LPW'(NLP - 1)) state_nxt = RUN;
      end
      RUN:     if (gvt > end_time) state_nxt = DRAIN;
      DRAIN:   if (busy == '0 && bus.new_vld == '0) state_nxt = DONE;
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      init_cnt      <= '0;
      busy          <= '0;
      gvt           <= '0;
      causality_err <= 1'b0;
      for (int unsigned i = 0; i < NCORE; i++) inflight[i] <= '0;
    end else begin
      state <= state_nxt;
      if (state == INIT) init_cnt <= init_cnt + LPW'(1);
      else               init_cnt <= '0;
      // Ack clears before dispatch sets, so a same-cycle set on one core wins.
      busy <= (busy & ~recv_gnt) | disp_gnt;
      for (int unsigned i = 0; i < NCORE; i++) begin
        if (disp_gnt[i]) inflight[i] <= bus.q_head.ts;
      end
      if (min_v && !(state == RUN && min_t < gvt)) gvt <= min_t;
      if (state == IDLE && start)                     causality_err <= 1'b0;
      else if (recv_vld && enq_sel.ts < gvt)          causality_err <= 1'b1;
    end
  end
endmodule
